// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment digit scanner.
//   - scan FSM state encodings (DEAD = all digits off, SHOW = one digit lit)
//   - default timing constants
//   - onehot() helper that turns a digit index into a one-hot enable vector
package seg_pkg;

  localparam logic [0:0] S_DEAD = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  typedef enum logic [0:0] {
    DEAD = S_DEAD,
    SHOW = S_SHOW
  } seg_state_e;

  localparam int DEFAULT_DEAD_CYCLES   = 8;
  localparam int DEFAULT_PRESCALE_BITS = 16;

  // One-hot vector wide enough for any realistic digit count; callers
  // truncate the result to their own digit width.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    logic [31:0] v;
    v = '0;
    if (idx < 32'd32) v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: free-running prescaler producing a one-clock tick every
// 2^PRESCALE_BITS clocks.
// Ports:
//   i_clk   - system clock
//   i_reset - asynchronous, active-high reset (counter returns to 0)
//   o_tick  - high for one clock while the counter sits at all-ones
module seg_tick_gen #(
  parameter int PRESCALE_BITS = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  logic [PRESCALE_BITS-1:0] cnt_q;
  logic [PRESCALE_BITS-1:0] cnt_d;

  // Plain binary increment; all-ones wraps to zero on its own.
  always_comb begin
    cnt_d = cnt_q + PRESCALE_BITS'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_tick = &cnt_q;

endmodule

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: multiplexed driver for an NDIGITS 7-segment display.
// A value loaded with i_load is held in a pending register and copied into
// the displayed shadow register only at a frame boundary, so a frame never
// mixes digits from two values. Each digit slot starts with a dead-time gap
// (all commons off) to avoid ghosting, then shows the digit until the next
// prescaler tick.
// Ports:
//   i_clk, i_reset - clock, asynchronous active-high reset
//   i_value        - packed nibbles, nibble k = digit k (digit 0 = LSD)
//   i_load         - one-clock strobe capturing i_value
//   i_hex          - hex/decimal glyph select, registered onto o_hex
//   i_blank_lz     - leading-zero blanking enable (sampled live)
//   o_nibble       - shadow nibble of the current digit index
//   o_hex          - registered i_hex
//   o_digit_en     - one-hot digit enable, zero during dead time / blanking
//   o_frame        - one-clock pulse after the scan wraps to digit 0
//   o_dbg_state    - current scan FSM state (S_DEAD / S_SHOW)
// Valid/ready: there is no back-pressure; i_load is a fire-and-forget strobe
// accepted on every clock it is high, the last one in a frame winning.
module seg_digit_scanner
  import seg_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS,
  parameter int DEAD_CYCLES   = DEFAULT_DEAD_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [4*NDIGITS-1:0] i_value,
  input  logic                 i_load,
  input  logic                 i_hex,
  input  logic                 i_blank_lz,
  output logic [3:0]           o_nibble,
  output logic                 o_hex,
  output logic [NDIGITS-1:0]   o_digit_en,
  output logic                 o_frame,
  output logic [0:0]           o_dbg_state
);

  localparam int IDX_W  = $clog2(NDIGITS);
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST =
    DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
  // With no dead time a tick goes straight to showing the next digit.
  localparam logic [0:0] AFTER_TICK = (DEAD_CYCLES == 0) ? S_SHOW : S_DEAD;

  logic tick;

  seg_tick_gen #(.PRESCALE_BITS(PRESCALE_BITS)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  logic [IDX_W-1:0]     index_q,     index_d;
  logic [0:0]           state_q,     state_d;
  logic [DEAD_W-1:0]    deadcnt_q,   deadcnt_d;
  logic [4*NDIGITS-1:0] shadow_q,    shadow_d;
  logic [4*NDIGITS-1:0] pending_q,   pending_d;
  logic                 pend_flag_q, pend_flag_d;
  logic [3:0]           nibble_q,    nibble_d;
  logic                 hex_q,       hex_d;
  logic [NDIGITS-1:0]   digit_en_q,  digit_en_d;
  logic                 frame_q,     frame_d;

  logic boundary;
  logic blank_cur;

  assign boundary = tick && (index_q == IDX_LAST);

  // Scan FSM, index and value registers.
  always_comb begin
    index_d     = index_q;
    state_d     = state_q;
    deadcnt_d   = deadcnt_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;

    if (tick) begin
      index_d   = boundary ? '0 : index_q + IDX_W'(1);
      state_d   = AFTER_TICK;
      deadcnt_d = '0;
    end else if (state_q == S_DEAD) begin
      if ((DEAD_CYCLES == 0) || (deadcnt_q == DEAD_LAST)) begin
        state_d   = S_SHOW;
        deadcnt_d = '0;
      end else begin
        deadcnt_d = deadcnt_q + DEAD_W'(1);
      end
    end

    if (i_load) begin
      pending_d   = i_value;
      pend_flag_d = 1'b1;
    end

    // A load landing on the boundary itself bypasses the pending register.
    if (boundary) begin
      shadow_d    = i_load ? i_value : (pend_flag_q ? pending_q : shadow_q);
      pend_flag_d = 1'b0;
    end
  end

  // Output stage: decoded from the current (pre-edge) state and index.
  always_comb begin
    nibble_d = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (index_q == IDX_W'(k)) nibble_d = shadow_q[4*k +: 4];
    end

    // Digit index_q is blank when it and every more significant nibble are 0.
    blank_cur = 1'b0;
    if (i_blank_lz && (index_q != '0)) begin
      blank_cur = 1'b1;
      for (int k = 0; k < NDIGITS; k++) begin
        if ((IDX_W'(k) >= index_q) && (shadow_q[4*k +: 4] != 4'd0)) begin
          blank_cur = 1'b0;
        end
      end
    end

    digit_en_d = '0;
    if ((state_q == S_SHOW) && !blank_cur) begin
      digit_en_d = NDIGITS'(onehot(32'(index_q)));
    end

    frame_d = boundary;
    hex_d   = i_hex;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      index_q     <= '0;
      state_q     <= S_DEAD;
      deadcnt_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      nibble_q    <= '0;
      hex_q       <= 1'b0;
      digit_en_q  <= '0;
      frame_q     <= 1'b0;
    end else begin
      index_q     <= index_d;
      state_q     <= state_d;
      deadcnt_q   <= deadcnt_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      nibble_q    <= nibble_d;
      hex_q       <= hex_d;
      digit_en_q  <= digit_en_d;
      frame_q     <= frame_d;
    end
  end

  assign o_nibble    = nibble_q;
  assign o_hex       = hex_q;
  assign o_digit_en  = digit_en_q;
  assign o_frame     = frame_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner with NDIGITS=4, PRESCALE_BITS=2,
// DEAD_CYCLES=1. Cycle c (counted from reset release) has digit slot
// d=((c-1)/4)%4, phase=(c-1)%4; phase 0 is the dead cycle, phases 1..3 show
// digit d. Frame f covers cycles 16f+1..16f+16 and o_frame is high at c%16==0.
module tb_seg_digit_scanner;

  localparam int ND = 4;
  localparam int PB = 2;
  localparam int DC = 1;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [15:0]   i_value;
  logic          i_load;
  logic          i_hex;
  logic          i_blank_lz;
  logic [3:0]    o_nibble;
  logic          o_hex;
  logic [ND-1:0] o_digit_en;
  logic          o_frame;
  logic [0:0]    o_dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seg_digit_scanner #(.NDIGITS(ND), .PRESCALE_BITS(PB), .DEAD_CYCLES(DC)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_value     (i_value),
    .i_load      (i_load),
    .i_hex       (i_hex),
    .i_blank_lz  (i_blank_lz),
    .o_nibble    (o_nibble),
    .o_hex       (o_hex),
    .o_digit_en  (o_digit_en),
    .o_frame     (o_frame),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input int c, input logic [15:0] sh, input logic blk);
    int d;
    int ph;
    d  = ((c - 1) / 4) % 4;
    ph = (c - 1) % 4;
    if (ph == 0) return 4'b0000;
    if (blk && (d > 0) && ((sh >> (4 * d)) == 16'h0000)) return 4'b0000;
    return 4'(1 << d);
  endfunction

  function automatic logic [3:0] exp_nib(input int c, input logic [15:0] sh);
    int d;
    logic [15:0] t;
    d = ((c - 1) / 4) % 4;
    t = sh >> (4 * d);
    return t[3:0];
  endfunction

  // Driver: advance one clock, sampling 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Advance n clocks checking enable, nibble and frame against the model.
  task automatic run(input int n, input logic [15:0] sh, input logic blk);
    for (int i = 0; i < n; i++) begin
      step();
      chk("digit_en", 32'(o_digit_en), 32'(exp_en(cyc, sh, blk)));
      chk("nibble",   32'(o_nibble),   32'(exp_nib(cyc, sh)));
      chk("frame",    32'(o_frame),    32'((cyc % 16) == 0));
    end
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [15:0] sh, input logic blk);
    i_load  = 1'b1;
    i_value = v;
    run(1, sh, blk);
    i_load  = 1'b0;
  endtask

  logic [3:0] last_nz;
  int         zero_run;

  initial begin
    i_reset    = 1'b1;
    i_value    = '0;
    i_load     = 1'b0;
    i_hex      = 1'b0;
    i_blank_lz = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_digit_en", 32'(o_digit_en), 32'h0);
    chk("rst_nibble",   32'(o_nibble),   32'h0);
    chk("rst_frame",    32'(o_frame),    32'h0);
    chk("rst_hex",      32'(o_hex),      32'h0);
    chk("rst_state",    32'(o_dbg_state), 32'h0);
    i_reset = 1'b0;
    cyc     = 0;

    // 1: basic scan pattern over two frames with zero shadow
    run(32, 16'h0000, 1'b0);

    // 2: mid-frame load waits for the frame boundary
    run(4, 16'h0000, 1'b0);
    load_pulse(16'h1234, 16'h0000, 1'b0);
    run(11, 16'h0000, 1'b0);
    run(16, 16'h1234, 1'b0);

    // 3: last load in a frame wins; load on the boundary applies directly
    run(2, 16'h1234, 1'b0);
    load_pulse(16'hAAAA, 16'h1234, 1'b0);
    run(2, 16'h1234, 1'b0);
    load_pulse(16'h5555, 16'h1234, 1'b0);
    run(10, 16'h1234, 1'b0);
    run(15, 16'h5555, 1'b0);
    load_pulse(16'h00F0, 16'h5555, 1'b0);
    run(15, 16'h00F0, 1'b0);
    load_pulse(16'h0070, 16'h00F0, 1'b0);

    // 4: leading-zero blanking
    i_blank_lz = 1'b1;
    run(15, 16'h0070, 1'b1);
    load_pulse(16'h0000, 16'h0070, 1'b1);
    run(16, 16'h0000, 1'b1);
    i_blank_lz = 1'b0;
    run(3, 16'h0000, 1'b0);

    // 5: hex passthrough is one clock late
    i_hex = 1'b1;
    chk("hex_before_edge", 32'(o_hex), 32'h0);
    run(1, 16'h0000, 1'b0);
    chk("hex_rise", 32'(o_hex), 32'h1);
    i_hex = 1'b0;
    run(1, 16'h0000, 1'b0);
    chk("hex_fall", 32'(o_hex), 32'h0);
    run(10, 16'h0000, 1'b0);
    load_pulse(16'h1234, 16'h0000, 1'b0);
    run(10, 16'h1234, 1'b0);   // now showing digit 2 (nibble 2)

    // 5b: asynchronous reset mid-SHOW, checked between clock edges
    #1;
    i_reset = 1'b1;
    #1;
    chk("async_digit_en", 32'(o_digit_en), 32'h0);
    chk("async_nibble",   32'(o_nibble),   32'h0);
    chk("async_state",    32'(o_dbg_state), 32'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    cyc     = 0;
    run(8, 16'h0000, 1'b0);

    // 6: random loads; enable never multi-hot, dead gap between digits
    last_nz  = '0;
    zero_run = 0;
    for (int i = 0; i < 1000; i++) begin
      i_load  = ($urandom_range(0, 3) == 0);
      i_value = 16'($urandom);
      step();
      chk("onehot0", 32'($countones(o_digit_en) <= 1), 32'h1);
      if (o_digit_en != '0) begin
        if ((last_nz != '0) && (o_digit_en != last_nz)) begin
          chk("dead_gap", 32'(zero_run >= 1), 32'h1);
        end
        last_nz  = o_digit_en;
        zero_run = 0;
      end else begin
        zero_run++;
      end
    end
    i_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
